// File: rtl/weight_sram_burst_if.sv
// Loader-write and burst-stream bus of the weight SRAM.
// The slave side is the memory; the master side is the loader and consumer.
interface weight_sram_burst_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W-1:0]        burst_len;
    logic signed [DATA_W-1:0] q;
    logic                     q_valid;
    logic                     q_ready;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output wr_en, wr_addr, wr_data, start, base_addr, burst_len, q_ready,
        input  q, q_valid, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, base_addr, burst_len, q_ready,
        output q, q_valid, busy, done, err
    );
endinterface

// File: rtl/weight_sram_burst.sv
// Single-port weight SRAM: the loader writes while idle, and a burst streams
// words base..base+len-1 through a 2-entry output buffer with ready/valid flow control.
module weight_sram_burst #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 156800,
    parameter int ADDR_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    weight_sram_burst_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic signed [DATA_W-1:0] mem [DEPTH];

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]        rem_q, rem_d;
    logic                     rd_vld_q, rd_vld_d;
    logic signed [DATA_W-1:0] rd_data_q;
    logic signed [DATA_W-1:0] head_q, head_d;
    logic signed [DATA_W-1:0] tail_q, tail_d;
    logic                     head_vld_q, head_vld_d;
    logic                     tail_vld_q, tail_vld_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [ADDR_W:0]          burst_end_s;
    logic                     start_ok_s;
    logic                     start_zero_s;
    logic                     start_bad_s;
    logic                     wr_ok_s;
    logic                     wr_drop_s;
    logic                     pop_s;
    logic                     last_pop_s;
    logic                     rd_en_s;
    logic [1:0]               occ_s;

    // Request decode; the end address is formed one bit wider so it cannot wrap.
    always_comb begin
        burst_end_s  = {1'b0, bus.base_addr} + {1'b0, bus.burst_len};
        start_ok_s   = 1'b0;
        start_zero_s = 1'b0;
        start_bad_s  = 1'b0;
        wr_ok_s      = 1'b0;
        wr_drop_s    = 1'b0;
        if ((state_q == ST_IDLE) && bus.start) begin
            if (bus.burst_len == {ADDR_W{1'b0}}) begin
                start_zero_s = 1'b1;
            end else if (burst_end_s <= DEPTH_X) begin
                start_ok_s = 1'b1;
            end else begin
                start_bad_s = 1'b1;
            end
        end else begin
            start_ok_s = 1'b0;
        end
        if (bus.wr_en) begin
            if ((state_q == ST_IDLE) && !bus.start && ({1'b0, bus.wr_addr} < DEPTH_X)) begin
                wr_ok_s = 1'b1;
            end else begin
                wr_drop_s = 1'b1;
            end
        end else begin
            wr_drop_s = 1'b0;
        end
    end

    // Reads are issued only while the words already owed, less any leaving now, fit the buffer.
    always_comb begin
        pop_s      = head_vld_q & bus.q_ready;
        occ_s      = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, rd_vld_q};
        last_pop_s = (state_q == ST_DRAIN) && pop_s && (occ_s == 2'd1);
        rd_en_s    = (state_q == ST_RUN) && (rem_q != {ADDR_W{1'b0}})
                     && ((occ_s < 2'd2) || pop_s);
    end

    // Burst sequencing: address/remaining counters and state transitions.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rem_d     = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d   = ST_RUN;
                    rd_addr_d = bus.base_addr;
                    rem_d     = bus.burst_len;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_en_s) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rem_d     = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output buffer: head drives q, tail catches a word arriving during a stall.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (tail_vld_q) begin
            if (pop_s) begin
                head_d     = tail_q;
                tail_vld_d = 1'b0;
            end else begin
                head_d = head_q;
            end
        end else if (head_vld_q) begin
            case ({pop_s, rd_vld_q})
                2'b11: begin
                    head_d = rd_data_q;
                end
                2'b10: begin
                    head_vld_d = 1'b0;
                end
                2'b01: begin
                    tail_d     = rd_data_q;
                    tail_vld_d = 1'b1;
                end
                default: begin
                    head_vld_d = head_vld_q;
                end
            endcase
        end else begin
            if (rd_vld_q) begin
                head_d     = rd_data_q;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end
    end

    always_comb begin
        rd_vld_d = rd_en_s;
        done_d   = start_zero_s;
        err_d    = start_bad_s | wr_drop_s;
    end

    // Control and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= {ADDR_W{1'b0}};
            rem_q      <= {ADDR_W{1'b0}};
            rd_vld_q   <= 1'b0;
            head_q     <= {DATA_W{1'b0}};
            tail_q     <= {DATA_W{1'b0}};
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rem_q      <= rem_d;
            rd_vld_q   <= rd_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Memory array keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Synchronous read port; rd_vld_q qualifies the data.
    always_ff @(posedge clk) begin
        if (rd_en_s) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign bus.q       = head_q;
    assign bus.q_valid = head_vld_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q | (last_pop_s & ~rst);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_weight_sram_burst.sv
// Bench for weight_sram_burst: a table of burst requests, hand-written reset and
// write-error sequences, and random bursts checked against a word-array model.
module tb_weight_sram_burst;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 156800;
    localparam int ADDR_W = 18;

    typedef enum int {RDY_ALL, RDY_TOGGLE, RDY_RAND} rdy_mode_e;

    typedef struct {
        int        base;
        int        len;
        rdy_mode_e mode;
        int        wr_cyc;
        int        wr_addr;
        int        wr_data;
        int        exp_words;
        int        exp_done;
        int        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   mem_m [DEPTH];
    vec_t tbl [14];

    weight_sram_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    weight_sram_burst #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = {ADDR_W{1'b0}};
        bus.wr_data   = {DATA_W{1'b0}};
        bus.start     = 1'b0;
        bus.base_addr = {ADDR_W{1'b0}};
        bus.burst_len = {ADDR_W{1'b0}};
        bus.q_ready   = 1'b0;
    endtask

    task automatic write_word(input int addr, input int data, input int exp_err);
        @(negedge clk);
        drive_idle();
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = DATA_W'(data);
        @(negedge clk);
        drive_idle();
        #1;
        check($sformatf("wr_err@%0d", addr), bus.err, exp_err);
        if (addr < DEPTH) mem_m[addr] = data;
    endtask

    task automatic run_burst(input vec_t v, input string tag);
        int exp_q[$];
        int got_q[$];
        int n_done = 0, n_err = 0;
        int first_idx = -1, done_idx = -1, err_idx = -1, last_hs = -1;
        int cyc = 0;
        int budget;
        int prev_q = 0;
        bit prev_stall = 1'b0;
        for (int i = 0; i < v.exp_words; i++) exp_q.push_back(mem_m[v.base + i]);
        budget = 4 * v.exp_words + 40;
        forever begin
            @(negedge clk);
            bus.start     = (cyc == 0);
            bus.base_addr = ADDR_W'(v.base);
            bus.burst_len = ADDR_W'(v.len);
            bus.wr_en     = (cyc == v.wr_cyc);
            bus.wr_addr   = ADDR_W'(v.wr_addr);
            bus.wr_data   = DATA_W'(v.wr_data);
            case (v.mode)
                RDY_ALL:    bus.q_ready = 1'b1;
                RDY_TOGGLE: bus.q_ready = ((cyc % 3) == 0);
                default:    bus.q_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                check({tag, " hold_valid"}, bus.q_valid, 1);
                check({tag, " hold_q"}, int'(bus.q), prev_q);
            end
            if (bus.q_valid && first_idx < 0) first_idx = cyc;
            if (bus.q_valid && bus.q_ready) begin
                got_q.push_back(int'(bus.q));
                last_hs = cyc;
            end
            if (bus.done) begin
                n_done++;
                done_idx = cyc;
            end
            if (bus.err) begin
                n_err++;
                if (err_idx < 0) err_idx = cyc;
            end
            prev_stall = bus.q_valid && !bus.q_ready;
            prev_q     = int'(bus.q);
            cyc++;
            if (cyc >= 3 && !bus.busy) break;
            if (cyc > budget) begin
                total++;
                bad++;
                $display("FAIL %s timeout: busy still %0d after %0d cycles", tag, bus.busy, cyc);
                break;
            end
        end
        drive_idle();
        check({tag, " q_valid_end"}, bus.q_valid, 0);
        check({tag, " words"}, got_q.size(), v.exp_words);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " done"}, n_done, v.exp_done);
        check({tag, " err"}, n_err, v.exp_err);
        if (v.exp_words > 0) check({tag, " done_on_last"}, done_idx, last_hs);
        if (v.exp_words > 0 && v.mode == RDY_ALL) begin
            check({tag, " latency"}, first_idx, 3);
            check({tag, " stream"}, last_hs - first_idx, v.exp_words - 1);
        end
        if (v.exp_words == 0) check({tag, " no_valid"}, first_idx, -1);
        if (v.exp_words == 0 && v.exp_done == 1) check({tag, " done_at"}, done_idx, 1);
        if (v.exp_words == 0 && v.exp_err == 1) check({tag, " err_at"}, err_idx, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   hs;
        int   n_done;
        int   n_qv;

        tbl[0]  = '{2,      4,      RDY_ALL,    -1, 0,  0,     4,  1, 0};
        tbl[1]  = '{2,      4,      RDY_TOGGLE, -1, 0,  0,     4,  1, 0};
        tbl[2]  = '{156790, 11,     RDY_ALL,    -1, 0,  0,     0,  0, 1};
        tbl[3]  = '{156790, 10,     RDY_ALL,    -1, 0,  0,     10, 1, 0};
        tbl[4]  = '{5,      0,      RDY_ALL,    -1, 0,  0,     0,  1, 0};
        tbl[5]  = '{20,     8,      RDY_ALL,    2,  27, 12345, 8,  1, 1};
        tbl[6]  = '{20,     8,      RDY_RAND,   -1, 0,  0,     8,  1, 0};
        tbl[7]  = '{0,      1,      RDY_ALL,    -1, 0,  0,     1,  1, 0};
        tbl[8]  = '{156799, 1,      RDY_TOGGLE, -1, 0,  0,     1,  1, 0};
        tbl[9]  = '{156800, 1,      RDY_ALL,    -1, 0,  0,     0,  0, 1};
        tbl[10] = '{262143, 262143, RDY_ALL,    -1, 0,  0,     0,  0, 1};
        tbl[11] = '{30,     5,      RDY_ALL,    0,  31, -5,    5,  1, 1};
        tbl[12] = '{40,     16,     RDY_RAND,   -1, 0,  0,     16, 1, 0};
        tbl[13] = '{156768, 32,     RDY_TOGGLE, -1, 0,  0,     32, 1, 0};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset q", int'(bus.q), 0);
        check("reset q_valid", bus.q_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) write_word(a, 100 + a, 0);
        for (int a = 8; a < 64; a++) write_word(a, int'($urandom_range(0, 65535)) - 32768, 0);
        for (int a = 156768; a < DEPTH; a++) write_word(a, int'($urandom_range(0, 65535)) - 32768, 0);
        write_word(DEPTH, 7, 1);
        write_word(262143, 8, 1);

        for (int i = 0; i < 14; i++) run_burst(tbl[i], $sformatf("vec%0d", i));

        // Reset two words into a six-word burst, with start and a write held during reset.
        hs     = 0;
        n_done = 0;
        for (int c = 0; c < 40 && hs < 2; c++) begin
            @(negedge clk);
            drive_idle();
            bus.q_ready   = 1'b1;
            bus.start     = (c == 0);
            bus.base_addr = ADDR_W'(10);
            bus.burst_len = ADDR_W'(6);
            #1;
            if (bus.q_valid) begin
                check($sformatf("rst_pre_word%0d", hs), int'(bus.q), mem_m[10 + hs]);
                hs++;
            end
            if (bus.done) n_done++;
        end
        check("rst_pre_count", hs, 2);
        @(negedge clk);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(10);
        bus.burst_len = ADDR_W'(6);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = ADDR_W'(12);
        bus.wr_data   = DATA_W'(9999);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        bus.q_ready = 1'b1;
        #1;
        check("rst_mid q_valid", bus.q_valid, 0);
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid err", bus.err, 0);
        check("rst_mid q", int'(bus.q), 0);
        n_qv = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) n_done++;
            if (bus.q_valid || bus.busy) n_qv++;
            @(negedge clk);
            #1;
        end
        check("rst_mid no_done", n_done, 0);
        check("rst_mid quiet", n_qv, 0);
        rv = '{10, 6, RDY_ALL, -1, 0, 0, 6, 1, 0};
        run_burst(rv, "post_rst");

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) == 0)
                write_word(int'($urandom_range(8, 63)), int'($urandom_range(0, 65535)) - 32768, 0);
            rv.len       = int'($urandom_range(1, 16));
            rv.base      = int'($urandom_range(0, 64 - rv.len));
            rv.mode      = RDY_RAND;
            rv.wr_cyc    = ($urandom_range(0, 3) == 0) ? 2 : -1;
            rv.wr_addr   = int'($urandom_range(0, 63));
            rv.wr_data   = int'($urandom_range(0, 65535)) - 32768;
            rv.exp_words = rv.len;
            rv.exp_done  = 1;
            rv.exp_err   = (rv.wr_cyc >= 0) ? 1 : 0;
            run_burst(rv, $sformatf("rnd%0d", r));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
